// File: rtl/car_pkg.sv
// Shared definitions for the car mode controller.
//   state_t        : operating modes of the top-level driving FSM
//   LED_*          : state_led display codes
//   CAR_HDR        : default command frame header (cmd_byte[7:6])
//   CMD_* / DET_*  : bit positions in the command vector and detector input
//   led_code()     : mode -> display code
//   apply_interlock: clears opposing drive pairs that are requested together
package car_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_ON     = 2'd1,
        ST_MANUAL = 2'd2,
        ST_SEMI   = 2'd3
    } state_t;

    localparam logic [3:0] LED_OFF    = 4'b0000;
    localparam logic [3:0] LED_ON     = 4'b0001;
    localparam logic [3:0] LED_MANUAL = 4'b0010;
    localparam logic [3:0] LED_SEMI   = 4'b0100;

    localparam logic [1:0] CAR_HDR = 2'b10;

    localparam int unsigned CMD_FWD     = 0;
    localparam int unsigned CMD_BACK    = 1;
    localparam int unsigned CMD_LEFT    = 2;
    localparam int unsigned CMD_RIGHT   = 3;
    localparam int unsigned CMD_PLACE   = 4;
    localparam int unsigned CMD_DESTROY = 5;

    localparam int unsigned DET_FRONT = 0;
    localparam int unsigned DET_BACK  = 1;
    localparam int unsigned DET_LEFT  = 2;
    localparam int unsigned DET_RIGHT = 3;

    function automatic logic [3:0] led_code(input state_t s);
        case (s)
            ST_ON:     return LED_ON;
            ST_MANUAL: return LED_MANUAL;
            ST_SEMI:   return LED_SEMI;
            default:   return LED_OFF;
        endcase
    endfunction

    function automatic logic [5:0] apply_interlock(input logic [5:0] c);
        logic [5:0] r;
        r = c;
        if (c[CMD_FWD] && c[CMD_BACK]) begin
            r[CMD_FWD]  = 1'b0;
            r[CMD_BACK] = 1'b0;
        end
        if (c[CMD_LEFT] && c[CMD_RIGHT]) begin
            r[CMD_LEFT]  = 1'b0;
            r[CMD_RIGHT] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer operating on 1 ms sample ticks.
//   sys_clk : system clock
//   rst_n   : async active-low reset
//   ms_tick : sample strobe, one cycle per millisecond
//   din     : synchronised raw button level
//   dout    : accepted level; follows din after DEBOUNCE_MS consecutive differing samples
module btn_debounce #(
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic ms_tick,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (ms_tick) begin
            if (din == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                dout <= din;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/car_mode_ctrl.sv
// Top-level mode controller for the simulated car.
//   sys_clk        : system clock
//   rst_n          : async active-low reset
//   power_on_btn   : raw button, long-press leaves OFF
//   power_off_btn  : raw button, edge forces OFF from any mode
//   manual_btn     : raw button, edge selects MANUAL
//   semi_btn       : raw button, edge selects SEMI_AUTO
//   cmd_in         : raw drive switches {destroy,place,right,left,back,fwd}
//   detector_in    : {right,left,back,front} obstacle flags
//   state_led      : mode display
//   cmd_byte       : {HDR, zero pad, cmd} frame towards the uart tx
//   cmd_valid      : frame pending
//   cmd_ready      : uart tx accepts the frame when valid & ready
module car_mode_ctrl
    import car_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned HOLD_MS       = 1000,
    parameter int unsigned DEBOUNCE_MS   = 20,
    parameter int unsigned KEEPALIVE_CYC = 5_000_000,
    parameter int unsigned NUM_CMD       = 6,
    parameter logic [1:0]  HDR           = CAR_HDR
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               power_on_btn,
    input  logic               power_off_btn,
    input  logic               manual_btn,
    input  logic               semi_btn,
    input  logic [NUM_CMD-1:0] cmd_in,
    input  logic [3:0]         detector_in,
    output logic [3:0]         state_led,
    output logic [7:0]         cmd_byte,
    output logic               cmd_valid,
    input  logic               cmd_ready
);

    localparam int unsigned MS_DIV = CLK_HZ / 1000;
    localparam int unsigned MSW    = $clog2(MS_DIV + 1);
    localparam int unsigned HW     = $clog2(HOLD_MS + 1);
    localparam int unsigned KW     = $clog2(KEEPALIVE_CYC);
    localparam logic [MSW-1:0] MS_LAST   = MSW'(MS_DIV - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_MS);
    localparam logic [KW-1:0]  KEEP_LAST = KW'(KEEPALIVE_CYC - 1);

    // ---------------- ms tick ----------------
    logic [MSW-1:0] ms_cnt;
    logic           ms_tick;

    assign ms_tick = (ms_cnt == MS_LAST);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)       ms_cnt <= '0;
        else if (ms_tick) ms_cnt <= '0;
        else              ms_cnt <= ms_cnt + 1'b1;
    end

    // ---------------- synchronisers ----------------
    // button order: {semi, manual, power_off, power_on}
    logic [3:0]         btn_s1, btn_s2;
    logic [NUM_CMD-1:0] cmd_s1, cmd_s2;
    logic [3:0]         det_s1, det_s2;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            cmd_s1 <= '0;
            cmd_s2 <= '0;
            det_s1 <= '0;
            det_s2 <= '0;
        end else begin
            btn_s1 <= {semi_btn, manual_btn, power_off_btn, power_on_btn};
            btn_s2 <= btn_s1;
            cmd_s1 <= cmd_in;
            cmd_s2 <= cmd_s1;
            det_s1 <= detector_in;
            det_s2 <= det_s1;
        end
    end

    // only the front detector steers the car today
    logic unused_det;
    assign unused_det = &{1'b0, det_s2[DET_RIGHT], det_s2[DET_LEFT], det_s2[DET_BACK]};

    // ---------------- debounce + edges ----------------
    logic [3:0] btn_db, btn_db_q, btn_rise;

    for (genvar g = 0; g < 4; g++) begin : g_db
        btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
            .sys_clk (sys_clk),
            .rst_n   (rst_n),
            .ms_tick (ms_tick),
            .din     (btn_s2[g]),
            .dout    (btn_db[g])
        );
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) btn_db_q <= '0;
        else        btn_db_q <= btn_db;
    end

    assign btn_rise = btn_db & ~btn_db_q;

    // ---------------- long-press ----------------
    state_t         state, next_state;
    logic           armed;
    logic [HW-1:0]  hold_cnt;

    // armed is held low outside OFF, so every entry to OFF starts disarmed
    // and a button still held from before cannot count towards power-on.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            hold_cnt <= '0;
        end else if (state != ST_OFF) begin
            armed    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            if (!btn_db[0]) armed <= 1'b1;
            if (!armed || !btn_db[0])                 hold_cnt <= '0;
            else if (ms_tick && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // ---------------- mode FSM ----------------
    always_comb begin
        next_state = state;
        if (btn_rise[1]) begin
            next_state = ST_OFF;
        end else begin
            case (state)
                ST_OFF:    if (hold_cnt == HOLD_LAST) next_state = ST_ON;
                ST_ON:     if (btn_rise[2])      next_state = ST_MANUAL;
                           else if (btn_rise[3]) next_state = ST_SEMI;
                ST_MANUAL: if (btn_rise[3]) next_state = ST_SEMI;
                ST_SEMI:   if (btn_rise[2]) next_state = ST_MANUAL;
                default:   next_state = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            state_led <= LED_OFF;
        end else begin
            state     <= next_state;
            state_led <= led_code(next_state);
        end
    end

    // ---------------- command gating ----------------
    // Commands live in a 6-bit vector; channels beyond NUM_CMD are never set.
    logic [5:0] raw6, cmd_next, cmd_q;

    always_comb begin
        raw6 = '0;
        raw6[NUM_CMD-1:0] = cmd_s2;
        cmd_next = '0;
        case (state)
            ST_MANUAL: cmd_next = apply_interlock(raw6);
            ST_SEMI: begin
                cmd_next[CMD_LEFT]  = raw6[CMD_LEFT]  & ~raw6[CMD_RIGHT];
                cmd_next[CMD_RIGHT] = raw6[CMD_RIGHT] & ~raw6[CMD_LEFT];
                cmd_next[CMD_FWD]   = ~det_s2[DET_FRONT];
            end
            default: cmd_next = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) cmd_q <= '0;
        else        cmd_q <= cmd_next;
    end

    // ---------------- framer ----------------
    logic [5:0]    last_cmd;
    logic [KW-1:0] keep_cnt;
    logic          pending;
    logic          changed;

    assign changed = (cmd_q != last_cmd);

    // A new frame is only launched from idle, so after an acceptance valid
    // drops for one cycle before the newest value goes out.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_byte  <= {HDR, 6'b0};
            cmd_valid <= 1'b0;
            last_cmd  <= '0;
            keep_cnt  <= '0;
            pending   <= 1'b0;
        end else if (cmd_valid) begin
            pending <= pending | changed;
            if (cmd_ready) begin
                cmd_valid <= 1'b0;
                keep_cnt  <= '0;
            end else if (keep_cnt != KEEP_LAST) begin
                keep_cnt <= keep_cnt + 1'b1;
            end
        end else begin
            if (keep_cnt != KEEP_LAST) keep_cnt <= keep_cnt + 1'b1;
            if (pending || changed || keep_cnt == KEEP_LAST) begin
                cmd_byte  <= {HDR, cmd_q};
                last_cmd  <= cmd_q;
                cmd_valid <= 1'b1;
                pending   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_car_mode_ctrl.sv
module tb_car_mode_ctrl;

    localparam int DEB  = 2;
    localparam int HOLD = 5;
    localparam int KEEP = 50;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       power_on_btn = 1'b0;
    logic       power_off_btn = 1'b0;
    logic       manual_btn = 1'b0;
    logic       semi_btn = 1'b0;
    logic [5:0] cmd_in = '0;
    logic [3:0] detector_in = '0;
    logic [3:0] state_led;
    logic [7:0] cmd_byte;
    logic       cmd_valid;
    logic       cmd_ready = 1'b1;

    int n_checks = 0;
    int n_err = 0;

    logic [7:0] frames[$];
    logic [7:0] last_frame = 8'h80;
    int         unstable = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_byte = '0;

    car_mode_ctrl #(
        .CLK_HZ        (1000),
        .HOLD_MS       (HOLD),
        .DEBOUNCE_MS   (DEB),
        .KEEPALIVE_CYC (KEEP),
        .NUM_CMD       (6),
        .HDR           (2'b10)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .power_on_btn  (power_on_btn),
        .power_off_btn (power_off_btn),
        .manual_btn    (manual_btn),
        .semi_btn      (semi_btn),
        .cmd_in        (cmd_in),
        .detector_in   (detector_in),
        .state_led     (state_led),
        .cmd_byte      (cmd_byte),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready)
    );

    always #5 sys_clk = ~sys_clk;

    // Frame monitor: records accepted frames and flags any change of a
    // pending frame before it has been accepted.
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && (!cmd_valid || cmd_byte !== prev_byte)) unstable++;
            if (cmd_valid && cmd_ready) begin
                frames.push_back(cmd_byte);
                last_frame = cmd_byte;
            end
            prev_hold = cmd_valid && !cmd_ready;
            prev_byte = cmd_byte;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive command a mode would send: 2 = manual, 3 = semi, others idle.
    function automatic logic [5:0] model(input int mode, input logic [5:0] c, input logic [3:0] d);
        logic [5:0] r;
        r = '0;
        if (mode == 2) begin
            r = c;
            if (c[0] && c[1]) r[1:0] = 2'b00;
            if (c[2] && c[3]) r[3:2] = 2'b00;
        end else if (mode == 3) begin
            r[0] = !d[0];
            r[3:2] = (c[2] && c[3]) ? 2'b00 : c[3:2];
        end
        return r;
    endfunction

    task automatic pulse(input int which);
        case (which)
            1: power_off_btn = 1'b1;
            2: manual_btn = 1'b1;
            default: semi_btn = 1'b1;
        endcase
        tick(4);
        power_off_btn = 1'b0;
        manual_btn = 1'b0;
        semi_btn = 1'b0;
        tick(6);
    endtask

    task automatic long_press(output int lat);
        power_on_btn = 1'b1;
        lat = 0;
        while (state_led !== 4'b0001 && lat < 30) begin
            tick();
            lat++;
        end
        power_on_btn = 1'b0;
        tick(8);
    endtask

    initial begin
        int lat;
        int nf;
        int k;
        logic [5:0] c;
        logic [3:0] d;
        // press latency: 2 sync flops + debounce + hold count + state register
        int exp_lat;
        exp_lat = 2 + DEB + HOLD + 1;

        tick(3);
        check("reset_led", {4'b0, state_led}, 8'h00);
        check("reset_byte", cmd_byte, 8'h80);
        check("reset_valid", {7'b0, cmd_valid}, 8'h00);
        rst_n = 1'b1;
        tick(2);

        power_on_btn = 1'b1;
        tick(3);
        power_on_btn = 1'b0;
        tick(15);
        check("short_press_led", {4'b0, state_led}, 8'h00);

        long_press(lat);
        check("long_press_latency", 8'(lat), 8'(exp_lat));
        check("on_led", {4'b0, state_led}, 8'h01);

        cmd_in = 6'b111111;
        tick(8);
        check("on_cmd_zero", cmd_byte, 8'h80);

        pulse(2);
        check("manual_led", {4'b0, state_led}, 8'h02);

        cmd_in = 6'b000010;
        tick(10);
        check("manual_back", last_frame, 8'h82);

        cmd_ready = 1'b0;
        cmd_in = 6'b000001;
        tick(8);
        check("held_valid", {7'b0, cmd_valid}, 8'h01);
        check("held_byte", cmd_byte, 8'h81);
        nf = frames.size();
        tick(5);
        check("held_byte_stable", cmd_byte, 8'h81);
        check("held_no_accept", 8'(frames.size()), 8'(nf));
        cmd_ready = 1'b1;
        tick(1);
        check("accept_count", 8'(frames.size()), 8'(nf + 1));
        check("accept_value", last_frame, 8'h81);
        check("valid_drops", {7'b0, cmd_valid}, 8'h00);

        cmd_in = 6'b000011;
        tick(10);
        check("fwd_back_lock", last_frame, 8'h80);
        cmd_in = 6'b001100;
        tick(10);
        check("left_right_lock", last_frame, 8'h80);

        for (int i = 0; i < 8; i++) begin
            c = 6'($urandom_range(0, 63));
            cmd_in = c;
            tick(8);
            check("manual_rand", last_frame, {2'b10, model(2, c, 4'b0)});
        end

        cmd_in = 6'b000000;
        tick(10);
        nf = frames.size();
        cmd_ready = 1'b0;
        cmd_in = 6'b000001;
        tick(6);
        cmd_in = 6'b000100;
        tick(3);
        cmd_in = 6'b001000;
        tick(3);
        check("multi_valid", {7'b0, cmd_valid}, 8'h01);
        check("multi_byte", cmd_byte, 8'h81);
        check("multi_stable", 8'(unstable), 8'h00);
        cmd_ready = 1'b1;
        tick(10);
        check("multi_frames", 8'(frames.size()), 8'(nf + 2));
        check("multi_last", last_frame, 8'h88);

        nf = frames.size();
        tick(35);
        check("no_early_repeat", 8'(frames.size()), 8'(nf));
        k = 0;
        while (frames.size() == nf && k < 25) begin
            tick();
            k++;
        end
        check("repeat_frame", 8'(frames.size()), 8'(nf + 1));
        check("repeat_value", last_frame, 8'h88);

        pulse(3);
        check("semi_led", {4'b0, state_led}, 8'h04);
        cmd_in = 6'b000000;
        detector_in = 4'b0001;
        tick(8);
        check("semi_blocked", last_frame, 8'h80);
        detector_in = 4'b0000;
        tick(8);
        check("semi_clear", last_frame, 8'h81);

        for (int i = 0; i < 8; i++) begin
            c = 6'($urandom_range(0, 63));
            d = 4'($urandom_range(0, 15));
            cmd_in = c;
            detector_in = d;
            tick(8);
            check("semi_rand", last_frame, {2'b10, model(3, c, d)});
        end

        pulse(2);
        check("semi_to_manual", {4'b0, state_led}, 8'h02);

        power_on_btn = 1'b1;
        tick(6);
        pulse(1);
        check("off_led", {4'b0, state_led}, 8'h00);
        check("off_cmd", last_frame, 8'h80);
        tick(20);
        check("no_reentry", {4'b0, state_led}, 8'h00);
        power_on_btn = 1'b0;
        tick(8);
        long_press(lat);
        check("relatch_latency", 8'(lat), 8'(exp_lat));
        check("relatch_led", {4'b0, state_led}, 8'h01);

        cmd_in = 6'b000000;
        pulse(2);
        cmd_ready = 1'b0;
        cmd_in = 6'b000001;
        tick(8);
        check("pre_reset_valid", {7'b0, cmd_valid}, 8'h01);
        rst_n = 1'b0;
        tick(1);
        check("midframe_valid", {7'b0, cmd_valid}, 8'h00);
        check("midframe_byte", cmd_byte, 8'h80);
        check("midframe_led", {4'b0, state_led}, 8'h00);
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        tick(2);

        check("final_stable", 8'(unstable), 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
